// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall encodings and FSM state type for pipe_ctrl
package pipe_ctrl_pkg;

    localparam int STALL_W   = 6;

    // Bit positions within the stall vector
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic [STALL_W-1:0] STALL_NONE  = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID_V  = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX_V  = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_RUN  = 2'd1,
        ST_MC_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clk   - clock
//   rst   - synchronous active-low reset
//   inc   - count up by one (holds at all-ones)
//   clr   - force to zero, wins over inc
//   value - current count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != '1)) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush control with multi-cycle execute countdown
//
// Ports:
//   clk          - clock
//   rst          - synchronous active-low reset
//   stallreq_id  - decode requests a bubble (level)
//   mc_req       - execute starts a multi-cycle op (sampled in IDLE only)
//   mc_len       - extra execute cycles for the op; 0 = not multi-cycle
//   flush_i      - flush the pipeline (level)
//   perf_clr     - clear the stall-cycle counter
//   stall_o      - per-stage hold vector {WB,MEM,EX,ID,IF,PC}
//   flush_o      - invalidate IF/ID, ID/EX, EX/MEM this cycle
//   mc_busy      - multi-cycle op in progress (registered)
//   mc_done      - one-cycle strobe: execute may release its result
//   mc_cnt       - remaining countdown (registered)
//   stall_cycles - saturating count of cycles with stall_o[PC] set
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               mc_req,
    input  logic [CNT_W-1:0]   mc_len,
    input  logic               flush_i,
    input  logic               perf_clr,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic               mc_busy,
    output logic               mc_done,
    output logic [CNT_W-1:0]   mc_cnt,
    output logic [PERF_W-1:0]  stall_cycles
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_o = STALL_NONE;
        flush_o = 1'b0;
        mc_done = 1'b0;

        // Outputs are held quiet while reset is asserted, even though the
        // inputs may be active; the registers are cleared on the edge anyway.
        if (rst) begin
            if (flush_i) begin
                flush_o = 1'b1;
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (mc_req && (mc_len != '0)) begin
                            stall_o = STALL_EX_V;
                            cnt_d   = mc_len;
                            state_d = ST_MC_RUN;
                        end else if (stallreq_id) begin
                            stall_o = STALL_ID_V;
                        end
                    end
                    ST_MC_RUN: begin
                        // EX hold already covers ID, so stallreq_id is masked.
                        stall_o = STALL_EX_V;
                        cnt_d   = cnt_q - CNT_W'(1);
                        // <=1 rather than ==1 so a corrupted zero count cannot wrap.
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_d   = '0;
                            state_d = ST_MC_DONE;
                        end
                    end
                    ST_MC_DONE: begin
                        mc_done = 1'b1;
                        stall_o = stallreq_id ? STALL_ID_V : STALL_NONE;
                        state_d = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        busy_d = (state_d == ST_MC_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign mc_busy = busy_q;
    assign mc_cnt  = cnt_q;

    sat_counter #(
        .W(PERF_W)
    ) u_perf (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall_o[STALL_PC]),
        .clr  (perf_clr),
        .value(stall_cycles)
    );

endmodule
